// File: rtl/mult_div_unit_if.sv
// Operand/result bus between the register bank and the multiply/divide unit.
// Optional MTHI/MTLO write port is present only when MD_MTHILO_EN is defined.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
`ifdef MD_MTHILO_EN
  logic             HiWe;
  logic             LoWe;
  logic [WIDTH-1:0] WData;
`endif

`ifdef MD_MTHILO_EN
  modport master (output Start, Op, A, B, HiWe, LoWe, WData,
                  input  Busy, Done, DivZero, Hi, Lo);
  modport slave  (input  Start, Op, A, B, HiWe, LoWe, WData,
                  output Busy, Done, DivZero, Hi, Lo);
`else
  modport master (output Start, Op, A, B,
                  input  Busy, Done, DivZero, Hi, Lo);
  modport slave  (input  Start, Op, A, B,
                  output Busy, Done, DivZero, Hi, Lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One result bit per clock: shift-add multiply, restoring shift-subtract divide.
// Operands are reduced to magnitudes at launch and the sign is fixed up in FIN.
// Optional macro MD_MTHILO_EN adds the MTHI/MTLO write port (HiWe/LoWe/WData).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  mult_div_unit_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Launch request decoded from the bus in IDLE.
  typedef struct packed {
    logic             div;
    logic             a_neg;
    logic             b_neg;
    logic             dz;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
  } req_t;

  state_t               state_q, state_d;
  logic                 div_q;
  logic                 sgn_pq_q;   // product / quotient sign
  logic                 sgn_r_q;    // remainder sign (follows dividend)
  logic                 dz_q;
  logic [2*WIDTH-1:0]   acc_q;      // mul: {partial hi, multiplier/lo}; div: {rem, dividend/quo}
  logic [WIDTH-1:0]     mag_q;      // multiplicand or divisor magnitude
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q, divzero_q;

  req_t                 req;
  logic                 launch;
  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign launch    = (state_q == IDLE) && bus.Start;
  assign last_iter = (cnt_q == CW'(WIDTH-1));

  // Operand decode: unsigned ops never report a negative operand.
  always_comb begin
    req.div   = bus.Op[1];
    req.a_neg = !bus.Op[0] && bus.A[WIDTH-1];
    req.b_neg = !bus.Op[0] && bus.B[WIDTH-1];
    req.dz    = bus.Op[1] && (bus.B == '0);
    req.a_mag = req.a_neg ? (~bus.A + 1'b1) : bus.A;
    req.b_mag = req.b_neg ? (~bus.B + 1'b1) : bus.B;
  end

  // One iteration step for each algorithm; the active one is picked in RUN.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    // and bit WIDTH of the difference is a clean borrow flag.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_ok    = !div_diff[WIDTH];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ok};
  end

  // Sign correction and HI/LO selection for the FIN write.
  always_comb begin
    prod_fix = sgn_pq_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = sgn_pq_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = sgn_r_q  ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (dz_q) begin
      // acc was loaded with {raw A, all ones} at launch
      res_hi = acc_q[2*WIDTH-1:WIDTH];
      res_lo = acc_q[WIDTH-1:0];
    end else if (div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: divide-by-zero skips the iteration phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.Start) state_d = req.dz ? FIN : RUN;
      RUN:  if (last_iter) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: launch capture, per-bit iteration, result commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q     <= 1'b0;
      sgn_pq_q  <= 1'b0;
      sgn_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            div_q     <= req.div;
            sgn_pq_q  <= req.a_neg ^ req.b_neg;
            sgn_r_q   <= req.a_neg;
            dz_q      <= req.dz;
            cnt_q     <= '0;
            divzero_q <= 1'b0;
            if (req.dz) begin
              acc_q <= {bus.A, {WIDTH{1'b1}}};
              mag_q <= '0;
            end else if (req.div) begin
              acc_q <= {{WIDTH{1'b0}}, req.a_mag};
              mag_q <= req.b_mag;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, req.b_mag};
              mag_q <= req.a_mag;
            end
          end
`ifdef MD_MTHILO_EN
          else begin
            if (bus.HiWe) hi_q <= bus.WData;
            if (bus.LoWe) lo_q <= bus.WData;
          end
`endif
        end
        RUN: begin
          acc_q <= div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        FIN: begin
          hi_q      <= res_hi;
          lo_q      <= res_lo;
          done_q    <= 1'b1;
          divzero_q <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = (state_q != IDLE);
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed cases plus a
// randomized run against a 64-bit arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if #(.WIDTH(W)) bus();

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Reference: returns {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: ref_op = sa * sb;
      2'b01: ref_op = ua * ub;
      2'b10: begin
        if (b == 0) ref_op = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          ref_op = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) ref_op = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_op = {ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  // Launch one op and wait for Done; lat = edges after the launch edge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int bcnt);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    lat = -1; bcnt = 0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) begin @(posedge CLK); #1; end
      if (bus.Done) begin lat = n; break; end
      if (bus.Busy) bcnt++;
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout op=%0d got no Done want Done", op);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.DivZero, bus.Hi, bus.Lo} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               bus.Busy, bus.Done, bus.DivZero, bus.Hi, bus.Lo);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat, bcnt;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++;
    if (bcnt !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bcnt); end
    checks++;
    if (bus.Hi !== 32'hFFFF_FFFE || bus.Lo !== 32'h0000_0001 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL multu_max got hi=%h lo=%h busy=%b want fffffffe 00000001 0",
               bus.Hi, bus.Lo, bus.Busy);
    end
    @(posedge CLK); #1;
    checks++;
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got done=%b want 0", bus.Done); end
  endtask

  task automatic test_mult_signed();
    int lat, bcnt;
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
    checks++;
    if (bus.Hi !== 32'hFFFF_FFFF || bus.Lo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg3x5 got %h_%h want ffffffff_fffffff1", bus.Hi, bus.Lo);
    end
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    checks++;
    if (bus.Hi !== 32'h4000_0000 || bus.Lo !== 32'h0) begin
      errors++; $display("FAIL mult_minxmin got %h_%h want 40000000_00000000", bus.Hi, bus.Lo);
    end
  endtask

  task automatic test_div();
    int lat, bcnt;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    checks++;
    if (bus.Lo !== 32'hFFFF_FFFD || bus.Hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg7by2 got hi=%h lo=%h want ffffffff fffffffd", bus.Hi, bus.Lo);
    end
    do_op(2'b11, 32'd100, 32'd7, lat, bcnt);
    checks++;
    if (bus.Lo !== 32'd14 || bus.Hi !== 32'd2 || bus.DivZero !== 1'b0) begin
      errors++; $display("FAIL divu_100by7 got hi=%0d lo=%0d dz=%b want 2 14 0", bus.Hi, bus.Lo, bus.DivZero);
    end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    checks++;
    if (bus.Lo !== 32'h8000_0000 || bus.Hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h want 0 80000000", bus.Hi, bus.Lo);
    end
  endtask

  task automatic test_divzero();
    int lat, bcnt;
    do_op(2'b11, 32'd5, 32'd0, lat, bcnt);
    checks++;
    if (lat !== 1 || bcnt !== 1) begin
      errors++; $display("FAIL divzero_latency got lat=%0d busy=%0d want 1 1", lat, bcnt);
    end
    checks++;
    if (bus.DivZero !== 1'b1 || bus.Hi !== 32'd5 || bus.Lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divzero_result got dz=%b hi=%h lo=%h want 1 00000005 ffffffff",
                         bus.DivZero, bus.Hi, bus.Lo);
    end
    do_op(2'b01, 32'd2, 32'd3, lat, bcnt);
    checks++;
    if (bus.DivZero !== 1'b0 || bus.Lo !== 32'd6) begin
      errors++; $display("FAIL divzero_clear got dz=%b lo=%0d want 0 6", bus.DivZero, bus.Lo);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int ndone;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd7; bus.B = 32'd9;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (4) @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 2'b11; bus.A = 32'd1; bus.B = 32'd0;
    @(negedge CLK);
    bus.Start = 1'b0;
    lat = -1; ndone = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge CLK); #1;
      if (bus.Done) begin
        ndone++;
        if (lat < 0) lat = n + 6;
      end
    end
    checks++;
    if (lat !== 33 || ndone !== 1) begin
      errors++; $display("FAIL ignore_start_timing got lat=%0d dones=%0d want 33 1", lat, ndone);
    end
    checks++;
    if (bus.Lo !== 32'd63 || bus.Hi !== 32'd0 || bus.DivZero !== 1'b0) begin
      errors++; $display("FAIL ignore_start_result got hi=%0d lo=%0d dz=%b want 0 63 0",
                         bus.Hi, bus.Lo, bus.DivZero);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd11; bus.B = 32'd13;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Hi !== 32'h0 || bus.Lo !== 32'h0 || bus.Done !== 1'b0) begin
      errors++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h done=%b want 0 0 0 0",
                         bus.Busy, bus.Hi, bus.Lo, bus.Done);
    end
    @(negedge CLK); RST = 1'b0;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge CLK); #1;
      if (bus.Done || bus.Busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", ndone); end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = ref_op(op, a, b);
      do_op(op, a, b, lat, bcnt);
      checks++;
      if ({bus.Hi, bus.Lo} !== exp) begin
        errors++; $display("FAIL rand_result op=%0d a=%h b=%h got %h_%h want %h_%h",
                           op, a, b, bus.Hi, bus.Lo, exp[63:32], exp[31:0]);
      end
      checks++;
      if (lat !== ((op[1] && b == 0) ? 1 : 33) || bus.DivZero !== (op[1] && b == 0)) begin
        errors++; $display("FAIL rand_timing op=%0d b=%h got lat=%0d dz=%b", op, b, lat, bus.DivZero);
      end
    end
  endtask

  // Start issued in the Done cycle is accepted straight away.
  task automatic test_back_to_back();
    int lat, bcnt;
    do_op(2'b01, 32'd3, 32'd4, lat, bcnt);
    do_op(2'b11, 32'd50, 32'd8, lat, bcnt);
    checks++;
    if (lat !== 33 || bus.Lo !== 32'd6 || bus.Hi !== 32'd2) begin
      errors++; $display("FAIL back_to_back got lat=%0d hi=%0d lo=%0d want 33 2 6", lat, bus.Hi, bus.Lo);
    end
  endtask

`ifdef MD_MTHILO_EN
  task automatic test_mthilo();
    int lat, bcnt;
    logic [31:0] lo_before;
    @(negedge CLK);
    bus.HiWe = 1'b1; bus.WData = 32'h1234;
    @(posedge CLK); #1;
    bus.HiWe = 1'b0;
    checks++;
    if (bus.Hi !== 32'h1234 || bus.Done !== 1'b0) begin
      errors++; $display("FAIL mthi got hi=%h done=%b want 00001234 0", bus.Hi, bus.Done);
    end
    @(negedge CLK);
    bus.HiWe = 1'b1; bus.LoWe = 1'b1; bus.WData = 32'hA5A5_0001;
    @(posedge CLK); #1;
    bus.HiWe = 1'b0; bus.LoWe = 1'b0;
    checks++;
    if (bus.Hi !== 32'hA5A5_0001 || bus.Lo !== 32'hA5A5_0001) begin
      errors++; $display("FAIL mthilo_both got hi=%h lo=%h want a5a50001", bus.Hi, bus.Lo);
    end
    lo_before = bus.Lo;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd2; bus.B = 32'd3;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (3) @(negedge CLK);
    bus.LoWe = 1'b1; bus.WData = 32'hDEAD;
    @(posedge CLK); #1;
    bus.LoWe = 1'b0;
    checks++;
    if (bus.Lo !== lo_before) begin
      errors++; $display("FAIL mtlo_busy got lo=%h want %h", bus.Lo, lo_before);
    end
    repeat (40) @(posedge CLK);
    #1;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd3; bus.B = 32'd4;
    bus.HiWe = 1'b1; bus.WData = 32'hBEEF;
    @(posedge CLK); #1;
    bus.Start = 1'b0; bus.HiWe = 1'b0;
    checks++;
    if (bus.Hi !== 32'd0 || bus.Busy !== 1'b1) begin
      errors++; $display("FAIL start_wins got hi=%h busy=%b want 0 1", bus.Hi, bus.Busy);
    end
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(posedge CLK); #1;
      if (bus.Done) begin lat = n; break; end
    end
    checks++;
    if (lat < 0 || bus.Lo !== 32'd12 || bus.Hi !== 32'd0) begin
      errors++; $display("FAIL start_wins_result got lat=%0d hi=%h lo=%h want 0 0000000c", lat, bus.Hi, bus.Lo);
    end
    bcnt = 0;
  endtask
`endif

  initial begin
    bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
`ifdef MD_MTHILO_EN
    bus.HiWe = 1'b0; bus.LoWe = 1'b0; bus.WData = '0;
`endif
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_divzero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef MD_MTHILO_EN
    test_mthilo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
